alu_sched: RTL

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched_pkg.sv | 11 +
 rtl/alu_sched_rr_pick.sv | 27 ++
 rtl/alu_sched.sv | 107 ++++++++++
 3 files changed

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: FSM state encoding and shared-ALU select codes for the ALU scheduler.
package alu_sched_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;
endpackage

// File: rtl/alu_sched_rr_pick.sv
// alu_sched_rr_pick: combinational round-robin picker, first request at or after ptr_i wins.
module alu_sched_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  int  j;
  logic found;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/alu_sched.sv
// alu_sched: four-phase scheduler granting N requesters round-robin access to one shared ALU.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] A_BUS,
  input  logic [N*W-1:0] B_BUS,
  input  logic [2*N-1:0] OP_BUS,
  output logic [W-1:0]   ALU_A,
  output logic [W-1:0]   ALU_B,
  output logic [1:0]     ALU_S,
  input  logic [W-1:0]   ALU_F,
  input  logic           ALU_C,
  output logic [N-1:0]   GNT,
  output logic [W-1:0]   RES,
  output logic           COUT,
  output logic [N-1:0]   DONE,
  output logic           BUSY
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  logic [1:0]    st_q, st_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, pick_idx;
  logic [N-1:0]  gnt_q, gnt_d, pick_gnt;
  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]    op_q, op_d;
  logic          cout_q, cout_d, drive;

  alu_sched_rr_pick #(.N(N), .IW(IW)) u_rr_pick (
    .req_i(REQ),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx)
  );

  always_comb begin
    st_d   = st_q;
    ptr_d  = ptr_q;
    idx_d  = idx_q;
    gnt_d  = gnt_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    res_d  = res_q;
    cout_d = cout_q;
    case (st_q)
      ST_IDLE: if (|REQ) begin
        st_d  = ST_ISSUE;
        idx_d = pick_idx;
        gnt_d = pick_gnt;
        a_d   = A_BUS[pick_idx*W +: W];
        b_d   = B_BUS[pick_idx*W +: W];
        op_d  = OP_BUS[pick_idx*2 +: 2];
      end
      ST_ISSUE: st_d = ST_CAPTURE;
      ST_CAPTURE: begin
        st_d   = ST_RESP;
        res_d  = ALU_F;
        cout_d = ALU_C;
      end
      ST_RESP: begin
        st_d  = ST_IDLE;
        gnt_d = '0;
        ptr_d = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q   <= ST_IDLE;
      ptr_q  <= '0;
      idx_q  <= '0;
      gnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      ptr_q  <= ptr_d;
      idx_q  <= idx_d;
      gnt_q  <= gnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      res_q  <= res_d;
      cout_q <= cout_d;
    end
  end

  // ALU is only driven while the operation is in flight, so it sees a quiet bus otherwise
  assign drive = (st_q == ST_ISSUE) || (st_q == ST_CAPTURE);
  assign ALU_A = drive ? a_q : '0;
  assign ALU_B = drive ? b_q : '0;
  assign ALU_S = drive ? op_q : '0;
  assign GNT   = gnt_q;
  assign DONE  = (st_q == ST_RESP) ? gnt_q : '0;
  assign BUSY  = st_q != ST_IDLE;
  assign RES   = res_q;
  assign COUT  = cout_q;
endmodule
